// File: rtl/dvp_pkg.sv
// rtl/dvp_pkg.sv - shared types and helpers for the DVP RGB565 capture front end
package dvp_pkg;

    localparam int X_BITS = 11;
    localparam int Y_BITS = 10;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SKIP       = 2'd1,
        ACTIVE     = 2'd2
    } dvp_state_t;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    function automatic logic [X_BITS-1:0] sat_inc_x(input logic [X_BITS-1:0] v);
        return (&v) ? v : v + X_BITS'(1);
    endfunction

    function automatic logic [Y_BITS-1:0] sat_inc_y(input logic [Y_BITS-1:0] v);
        return (&v) ? v : v + Y_BITS'(1);
    endfunction

endpackage

// File: rtl/dvp_byte_pair.sv
// rtl/dvp_byte_pair.sv - href-gated byte pairing into RGB565 pixels with odd-byte detect
module dvp_byte_pair
    import dvp_pkg::*;
#(
    parameter int HI_FIRST = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic       href,
    input  logic [7:0] data,
    output logic       pix_valid,
    output rgb565_t    pix_data,
    output logic       odd_byte
);

    logic       phase;
    logic [7:0] lat;

    // phase still high once href has dropped means the line ended on a dangling byte
    assign odd_byte = en & ~href & phase;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase     <= 1'b0;
            lat       <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
        end else begin
            pix_valid <= 1'b0;
            if (en && href) begin
                if (!phase) begin
                    lat   <= data;
                    phase <= 1'b1;
                end else begin
                    phase     <= 1'b0;
                    pix_valid <= 1'b1;
                    pix_data  <= (HI_FIRST != 0) ? {lat, data} : {data, lat};
                end
            end else begin
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dvp_rgb565_capture.sv
// rtl/dvp_rgb565_capture.sv - DVP capture top: FSM, x/y counters, error flags; DVP_CAPTURE_STATS_EN adds size stats
module dvp_rgb565_capture
    import dvp_pkg::*;
#(
    parameter int SKIP_FRAMES = 10,
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720,
    parameter int HI_FIRST    = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_data,
    output logic              o_vsync,
    output logic              o_href,
    output logic              o_valid,
    output logic [15:0]       o_data,
    output logic [X_BITS-1:0] o_x,
    output logic [Y_BITS-1:0] o_y,
    output logic [15:0]       o_frame_cnt,
    output logic              o_line_err,
    output logic              o_frame_err
`ifdef DVP_CAPTURE_STATS_EN
    ,
    output logic [X_BITS-1:0] o_last_width,
    output logic [Y_BITS-1:0] o_last_height
`endif
);

    dvp_state_t state, state_n;
    logic [15:0] skip_cnt, skip_n;

    logic       vsync_d, vsync_d2, href_d, href_d2;
    logic [7:0] data_d;
    logic [1:0] arm;

    logic        pix_valid, odd_byte;
    rgb565_t     pix_data;
    logic [X_BITS-1:0] x_cnt, line_px;
    logic [Y_BITS-1:0] y_cnt, frame_lines;

    logic active, vsync_rise, href_rise, href_fall, line_end, line_bad, frame_end;

    // arm keeps the reset value of the delayed copy from faking an edge on reset exit
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_d  <= 1'b0;
            vsync_d2 <= 1'b0;
            href_d   <= 1'b0;
            href_d2  <= 1'b0;
            data_d   <= '0;
            arm      <= '0;
        end else begin
            vsync_d  <= i_vsync;
            vsync_d2 <= vsync_d;
            href_d   <= i_href;
            href_d2  <= href_d;
            data_d   <= i_data;
            arm      <= {arm[0], 1'b1};
        end
    end

    assign active     = (state == ACTIVE);
    assign vsync_rise = arm[1] & vsync_d & ~vsync_d2;
    assign href_rise  = arm[1] & href_d & ~href_d2;
    assign href_fall  = arm[1] & ~href_d & href_d2;
    assign line_end   = active & href_fall;
    assign frame_end  = active & vsync_rise;

    // the last pixel of a line is still in flight when href falls, so count it here
    assign line_px     = pix_valid ? sat_inc_x(x_cnt) : x_cnt;
    assign line_bad    = line_end & (odd_byte | (line_px != X_BITS'(H_ACT)));
    assign frame_lines = line_end ? sat_inc_y(y_cnt) : y_cnt;

    assign o_vsync = vsync_d2;
    assign o_href  = href_d2 & active;

    dvp_byte_pair #(.HI_FIRST(HI_FIRST)) u_pair (
        .clk       (clk),
        .rstn      (rstn),
        .en        (active),
        .href      (href_d),
        .data      (data_d),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .odd_byte  (odd_byte)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= WAIT_FRAME;
            skip_cnt <= '0;
        end else begin
            state    <= state_n;
            skip_cnt <= skip_n;
        end
    end

    always_comb begin
        state_n = state;
        skip_n  = skip_cnt;
        case (state)
            WAIT_FRAME: begin
                if (vsync_rise) begin
                    skip_n  = '0;
                    state_n = (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
                end
            end
            SKIP: begin
                if (vsync_rise) begin
                    skip_n = skip_cnt + 16'd1;
                    if (skip_n == 16'(SKIP_FRAMES)) begin
                        state_n = ACTIVE;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_x         <= '0;
            o_y         <= '0;
            o_frame_cnt <= '0;
            o_line_err  <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (href_rise) begin
                x_cnt <= '0;
            end else if (pix_valid) begin
                x_cnt <= sat_inc_x(x_cnt);
            end
            if (vsync_rise) begin
                y_cnt <= '0;
            end else if (line_end) begin
                y_cnt <= sat_inc_y(y_cnt);
            end
            o_valid <= pix_valid;
            if (pix_valid) begin
                o_data <= pix_data;
                o_x    <= x_cnt;
                o_y    <= y_cnt;
            end
            if (frame_end) begin
                o_frame_cnt <= o_frame_cnt + 16'd1;
                o_frame_err <= (frame_lines != Y_BITS'(V_ACT));
            end
            // a line closing in the same cycle as vsync rise reports into the new frame
            o_line_err <= (o_line_err & ~vsync_rise) | line_bad;
        end
    end

`ifdef DVP_CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_last_width  <= '0;
            o_last_height <= '0;
        end else begin
            if (line_end) begin
                o_last_width <= line_px;
            end
            if (frame_end) begin
                o_last_height <= frame_lines;
            end
        end
    end
`endif

endmodule

// File: doc/dvp_rgb565_capture.md
Name: dvp_rgb565_capture

Overview:
- Camera-side front end. Samples the 8-bit DVP bus (vsync, href, byte data) and pairs bytes into 16-bit RGB565 pixels.
- Drops the first SKIP_FRAMES frames while the sensor settles, counts pixel x/y and flags malformed lines and frames.
- Feeds the HDMI display stage, which consumes vsync/href/16-bit data.

Parameters:
- SKIP_FRAMES, 10, vsync rising edges to discard before output is enabled (0 = first full frame is output).
- H_ACT, 1280, expected pixels per line.
- V_ACT, 720, expected lines per frame.
- HI_FIRST, 1, 1 = first byte of a pair is data[15:8]; 0 = first byte is data[7:0].

Ports:
- clk  in  1  pixel-byte clock (DVP PCLK domain)
- rstn  in  1  reset
- i_vsync  in  1  frame sync, active high; frame boundary = rising edge
- i_href  in  1  line valid, active high
- i_data  in  8  DVP byte
- o_vsync  out  1  i_vsync delayed 2 cycles, always forwarded
- o_href  out  1  i_href delayed 2 cycles, gated by ACTIVE
- o_valid  out  1  one-cycle pixel strobe
- o_data  out  16  RGB565 pixel, held between strobes
- o_x  out  11  pixel index of o_data within the line
- o_y  out  10  line index of o_data
- o_frame_cnt  out  16  frames output since ACTIVE, wraps
- o_line_err  out  1  sticky: a line had pixel count != H_ACT or an odd byte count; cleared at vsync rise
- o_frame_err  out  1  sticky: previous frame line count != V_ACT; cleared at next vsync rise

Behaviour:
- Reset: clk is the clock; reset rstn is asynchronous, active-low.
  - All outputs 0, state WAIT_FRAME, all counters 0, byte phase 0.
  - Reset mid-line abandons any partial pixel.
- Stage 1 registers all inputs. Vsync/href edges are detected between stage 1 and its delayed copy.
- State machine:
  - WAIT_FRAME: on the first vsync rise, go to SKIP. If SKIP_FRAMES==0, go directly to ACTIVE.
  - SKIP: a skip counter increments per vsync rise. When the counter reaches SKIP_FRAMES on a vsync rise, go to ACTIVE.
  - ACTIVE: terminal; stays until reset.
  - A frame already in progress at reset exit is never output.
- Byte pairing (ACTIVE only):
  - Phase toggles each cycle href_d is high; it is forced to 0 when href_d is low.
  - Phase 0 byte is latched. The phase 1 byte combines with the latched byte per HI_FIRST.
  - o_data updates and o_valid pulses 2 cycles after the input edge that sampled the second byte. With continuous href, o_valid is high every other cycle.
- Odd byte count: href falls with phase==1. The dangling byte is discarded, no o_valid, o_line_err set.
- Counters:
  - o_x: 0 for the first pixel of a line; increments after each o_valid; reset on href rise.
  - o_y: increments on href fall; reset on vsync rise.
  - o_x and o_y saturate at all-ones; they do not wrap.
  - At href fall, pixel count != H_ACT sets o_line_err.
  - At vsync rise, line count != V_ACT sets o_frame_err. This check is skipped for the vsync rise that enters ACTIVE.
- o_frame_cnt increments on each vsync rise while in ACTIVE and wraps at 16 bits.
- Simultaneous events:
  - Vsync rise in the same cycle as href fall: the line check completes first, then o_y is cleared.
  - Error clear and error set in the same cycle: set wins for the new frame. The clear applies to old status only.
- o_href/o_valid are 0 outside ACTIVE. o_vsync is forwarded in all states so downstream sync generation can lock.

Optional Feature:
- Macro: DVP_CAPTURE_STATS_EN.
- Defined:
  - Adds output ports o_last_width (11) and o_last_height (10), the measured pixel and line counts of the last completed line and frame.
  - Both update at href fall and vsync rise respectively; reset 0.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package dvp_pkg holds:
  - the state enum (WAIT_FRAME, SKIP, ACTIVE);
  - X_BITS=11, Y_BITS=10;
  - the RGB565 typedef (struct r5/g6/b5).
- One sub-module, dvp_byte_pair: href-gated phase toggle, byte latch, pixel strobe and odd-byte detect.
- The top level holds the FSM, counters and error logic.

Test Plan:
1. SKIP_FRAMES=2, three 4x2-pixel frames (H_ACT=4, V_ACT=2) -> no o_valid in frames 1-2; 8 strobes in frame 3; o_frame_cnt=1 after the 4th vsync rise.
2. HI_FIRST=1, bytes 0xF8,0x1F -> o_data=0xF81F, o_x=0, o_valid exactly 2 cycles after the 0x1F sample. HI_FIRST=0 -> 0x1FF8.
3. Line of 7 bytes with H_ACT=4 -> 3 strobes, o_line_err=1, cleared at next vsync rise. A clean next frame keeps it 0.
4. Frame with 3 lines with V_ACT=2 -> o_frame_err=1 after the following vsync rise.
5. Reset released mid-frame with href toggling -> outputs stay 0 until the first vsync rise. rstn asserted mid-line in ACTIVE -> outputs 0 immediately, state WAIT_FRAME.
6. DVP_CAPTURE_STATS_EN defined, 1280x720 frame -> o_last_width=1280 and o_last_height=720 after vsync rise, error flags 0.
